// File: rtl/uart_tx_autocfg_pkg.sv
// Shared constants for the auto-configured UART transmit path.
// Parity codes are the same ones the autobaud/autoparity detector produces,
// so the detector output can be wired straight into the transmitter.
// FSM state encodings are plain localparams so that legacy code and the
// receiver can share them.
package uart_tx_autocfg_pkg;

  // Parity codes (a code of 3 is treated like PAR_NONE)
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Transmitter FSM states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // A parity bit is sent only for the two real parity codes.
  function automatic logic par_enabled(input logic [1:0] code);
    return (code == PAR_ODD) || (code == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_autocfg_baud_tick_gen.sv
// 16x oversampling tick generator.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : restart the count from 0
//   en           : count only while high
//   dvsr[11:0]   : clock cycles per tick (0 and 1 both mean every cycle)
//   tick         : one-cycle pulse on the last count of each period
// The receiver can reuse this block once it switches to the detected rate.
module baud_tick_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic [11:0] dvsr,
  output logic        tick
);

  logic [11:0] cnt_q, cnt_d;
  logic [11:0] last;

  always_comb begin
    // Divisors of 0 and 1 collapse to a period of one cycle.
    last  = (dvsr <= 12'd1) ? 12'd0 : dvsr - 12'd1;
    tick  = en && (cnt_q == last);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? 12'd0 : cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_autocfg.sv
// UART transmitter running at the divisor/parity found by the autobaud and
// autoparity detector.
// Ports:
//   clk, reset_n   : 50 MHz clock, asynchronous active-low reset
//   baud_dvsr[11:0]: cycles per 16x tick, latched when a byte is accepted
//   parity_bit[1:0]: parity code (0/3 none, 1 odd, 2 even), latched likewise
//   tx_start, din  : send request and byte, accepted only while not busy
//   tx             : serial line, idle high, registered
//   tx_busy        : high from the cycle after acceptance through done
//   tx_done_tick   : one-cycle pulse in the last cycle of the stop bit
module uart_tx_autocfg
  import uart_tx_autocfg_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [11:0]     baud_dvsr,
  input  logic [1:0]      parity_bit,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int             NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [NW-1:0]  N_LAST = NW'(DBIT - 1);
  localparam logic [3:0]     S_STOP = 4'(SB_TICK - 1);

  logic [2:0]      state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shift_q, shift_d;
  logic [11:0]     dvsr_q, dvsr_d;
  logic [1:0]      par_q, par_d;
  logic            pbit_q, pbit_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tx_q, tx_d;
  logic            accept;
  logic            tick;

  // Parity comes from the byte as presented at acceptance, not from the
  // bits as they are shifted out.
  logic [DBIT:0] xor_chain;
  assign xor_chain[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < DBIT; gi++) begin : g_par
      assign xor_chain[gi+1] = xor_chain[gi] ^ din[gi];
    end
  endgenerate

  baud_tick_gen u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept),
    .en      (busy_q),
    .dvsr    (dvsr_q),
    .tick    (tick)
  );

  // busy_q also covers the done cycle, so a request there is refused.
  assign accept = tx_start && !busy_q && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    par_d   = par_q;
    pbit_d  = pbit_q;
    busy_d  = done_q ? 1'b0 : busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          s_d     = '0;
          n_d     = '0;
          shift_d = din;
          dvsr_d  = baud_dvsr;
          par_d   = parity_bit;
          pbit_d  = (parity_bit == PAR_ODD) ? ~xor_chain[DBIT] : xor_chain[DBIT];
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) begin
              state_d = par_enabled(par_q) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (s_q == S_STOP) begin
            s_d     = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line follows the current state one edge later, which gives the
  // single cycle of latency and keeps done aligned with the stop bit's end.
  always_comb begin
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = pbit_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      par_q   <= PAR_NONE;
      pbit_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      par_q   <= par_d;
      pbit_q  <= pbit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule
